// File: rtl/step_controller.sv
// step_controller: synchronizes and debounces a push-button and issues exactly
// one registered 1-cycle step_pulse per accepted press, counting issued steps.
// Optional free-run stepping is compiled in when the macro AUTO_RUN_EN is defined;
// without it run_en is ignored and no period counter exists.
module step_controller #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20,
   parameter int STEP_W          = 16,
   parameter int RUN_PERIOD      = 50000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              btn_raw,
   input  logic              run_en,
   output logic              step_pulse,
   output logic [STEP_W-1:0] step_count,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, DEBOUNCE, PULSE, RELEASE} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             s1;
   logic             sync;
   logic             auto_fire;
   logic             auto_step;

   // Two-flop synchronizer for the asynchronous button level.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1   <= 1'b0;
         sync <= 1'b0;
      end else begin
         s1   <= btn_raw;
         sync <= s1;
      end
   end

`ifdef AUTO_RUN_EN
   localparam int PER_W = (RUN_PERIOD > 2) ? $clog2(RUN_PERIOD) : 1;
   // The counter restarts instead of reaching RUN_PERIOD-1, so together with
   // the PULSE cycle (where it holds) auto steps are RUN_PERIOD cycles apart.
   localparam logic [PER_W-1:0] PER_LAST = PER_W'(RUN_PERIOD - 2);

   logic [PER_W-1:0] period_cnt;
   logic [PER_W-1:0] period_nxt;

   // Period counter: runs only in IDLE with no button activity, cleared by run_en=0.
   always_comb begin
      period_nxt = period_cnt;
      auto_fire  = 1'b0;
      if (!run_en) begin
         period_nxt = '0;
      end else if (state == IDLE && !sync) begin
         if (period_cnt == PER_LAST) begin
            period_nxt = '0;
            auto_fire  = 1'b1;
         end else begin
            period_nxt = period_cnt + PER_W'(1);
         end
      end
   end

   // Period counter register and marker that the current PULSE came from auto-run.
   always_ff @(posedge clk) begin
      if (reset) begin
         period_cnt <= '0;
         auto_step  <= 1'b0;
      end else begin
         period_cnt <= period_nxt;
         auto_step  <= (state == IDLE) && !sync && auto_fire;
      end
   end
`else
   logic unused_run_en;
   assign unused_run_en = run_en;
   assign auto_fire     = 1'b0;
   assign auto_step     = 1'b0;
`endif

   // Next-state logic: press debounce, single pulse, release debounce.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (sync)           state_nxt = DEBOUNCE;
            else if (auto_fire) state_nxt = PULSE;
         end
         DEBOUNCE: begin
            if (!sync)                 state_nxt = IDLE;
            else if (cnt == CNT_LAST)  state_nxt = PULSE;
            else                       cnt_nxt   = cnt + CNT_W'(1);
         end
         PULSE: begin
            cnt_nxt   = '0;
            state_nxt = auto_step ? IDLE : RELEASE;
         end
         RELEASE: begin
            if (sync)                  cnt_nxt   = '0;
            else if (cnt == CNT_LAST)  state_nxt = IDLE;
            else                       cnt_nxt   = cnt + CNT_W'(1);
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, counter and registered outputs; step_count advances as PULSE is entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         step_pulse <= 1'b0;
         busy       <= 1'b0;
         step_count <= '0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         step_pulse <= (state_nxt == PULSE);
         busy       <= (state_nxt != IDLE);
         if (state_nxt == PULSE) step_count <= step_count + STEP_W'(1);
      end
   end

endmodule

// File: tb/tb_step_controller.sv
// Scoreboard bench for step_controller (DEBOUNCE_CYCLES=4, STEP_W=2, RUN_PERIOD=5).
// Stimulus pushes the expected pulse cycle and count; a monitor pops on each step_pulse.
module tb_step_controller;

   logic       clk;
   logic       reset;
   logic       btn_raw;
   logic       run_en;
   logic       step_pulse;
   logic [1:0] step_count;
   logic       busy;

   typedef struct {
      int         cyc;
      logic [1:0] cnt;
   } exp_t;

   exp_t       sb_q[$];
   exp_t       mon_e;
   int         cyc = 0;
   int         vectors = 0;
   int         miscompares = 0;
   logic [1:0] exp_cnt = 2'd0;

   step_controller #(
      .DEBOUNCE_CYCLES(4),
      .CNT_W(3),
      .STEP_W(2),
      .RUN_PERIOD(5)
   ) dut (
      .clk(clk),
      .reset(reset),
      .btn_raw(btn_raw),
      .run_en(run_en),
      .step_pulse(step_pulse),
      .step_count(step_count),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every step_pulse must match the next scoreboard entry.
   always @(negedge clk) begin
      if (step_pulse) begin
         vectors++;
         if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_pulse: pulse at cycle %0d count=%0d, required no pulse", cyc, step_count);
         end else begin
            mon_e = sb_q.pop_front();
            if (cyc != mon_e.cyc || step_count != mon_e.cnt) begin
               miscompares++;
               $display("FAIL pulse: got cycle %0d count %0d, required cycle %0d count %0d",
                        cyc, step_count, mon_e.cyc, mon_e.cnt);
            end
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // Expect a pulse 'offset' edges from now carrying the next step number.
   task automatic push_exp(input int offset);
      exp_t e;
      exp_cnt = exp_cnt + 2'd1;
      e.cyc   = cyc + offset;
      e.cnt   = exp_cnt;
      sb_q.push_back(e);
   endtask

   // Full press: btn high for 'hold' cycles, then verify release timing of busy.
   task automatic press(input int hold);
      btn_raw = 1'b1;
      push_exp(7);
      tick(hold);
      check("busy_held", busy, 1);
      btn_raw = 1'b0;
      tick(5);
      check("busy_release_pending", busy, 1);
      tick(1);
      check("busy_release_done", busy, 0);
      check("count_after_press", step_count, exp_cnt);
   endtask

   initial begin
      reset   = 1'b1;
      btn_raw = 1'b1;
      run_en  = 1'b0;

      // Reset with button held, then the held button counts as a fresh press.
      tick(2);
      check("reset_pulse", step_pulse, 0);
      check("reset_count", step_count, 0);
      check("reset_busy", busy, 0);
      reset = 1'b0;
      push_exp(7);
      tick(10);
      check("held_reset_busy", busy, 1);
      check("held_reset_count", step_count, 1);
      btn_raw = 1'b0;
      tick(8);
      check("held_reset_idle", busy, 0);

      // Clean press held 20 cycles.
      press(20);

      // Glitch of 3 cycles is rejected.
      btn_raw = 1'b1;
      tick(3);
      check("glitch_busy", busy, 1);
      btn_raw = 1'b0;
      tick(8);
      check("glitch_idle", busy, 0);
      check("glitch_count", step_count, exp_cnt);

      // Reset in the middle of debounce aborts the press.
      btn_raw = 1'b1;
      tick(4);
      check("abort_busy", busy, 1);
      reset = 1'b1;
      tick(1);
      check("abort_reset_busy", busy, 0);
      check("abort_reset_count", step_count, 0);
      exp_cnt = 2'd0;
      btn_raw = 1'b0;
      reset   = 1'b0;
      tick(10);
      check("abort_count", step_count, 0);

      // Bouncing release: no second pulse, busy until 4 stable-low cycles.
      btn_raw = 1'b1;
      push_exp(7);
      tick(12);
      for (int i = 0; i < 5; i++) begin
         btn_raw = (i % 2 == 0) ? 1'b0 : 1'b1;
         tick(2);
         check("bounce_busy", busy, 1);
      end
      tick(3);
      check("bounce_settle_busy", busy, 1);
      tick(1);
      check("bounce_idle", busy, 0);
      check("bounce_count", step_count, exp_cnt);

      // Wrap: four more presses walk the 2-bit count through 2,3,0,1.
      for (int i = 0; i < 4; i++) press(10);

`ifdef AUTO_RUN_EN
      // Free run: pulses every 5 cycles.
      tick(2);
      run_en = 1'b1;
      push_exp(4);
      push_exp(9);
      push_exp(14);
      tick(14);
      run_en = 1'b0;
      tick(10);
      check("auto_count", step_count, exp_cnt);

      // Press during free run: one button pulse, auto resumes after release debounce.
      run_en  = 1'b1;
      btn_raw = 1'b1;
      push_exp(7);
      push_exp(18);
      push_exp(23);
      tick(10);
      btn_raw = 1'b0;
      tick(13);
      run_en = 1'b0;
      tick(10);
      check("auto_press_count", step_count, exp_cnt);
`endif

      for (int i = 0; i < 50 && sb_q.size() != 0; i++) tick(1);
      check("scoreboard_drained", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
